// File: rtl/fifo_stripe.sv
`default_nettype none
// fifo_stripe: round-robin striped FIFO built from `lanes` circular-buffer lanes of `depth` entries.
// Optional synchronous clear (adds input `flush`) when FIFO_STRIPE_FLUSH_EN is defined.
module fifo_stripe #(
  parameter int width = 96,
  parameter int lanes = 4,
  parameter int depth = 2
) (
  input  logic                             CLK,
  input  logic                             nRST,
  input  logic                             in_enq__ENA,
  input  logic [width-1:0]                 in_enq_v,
  output logic                             in_enq__RDY,
  input  logic                             out_deq__ENA,
  output logic                             out_deq__RDY,
  output logic [width-1:0]                 out_first,
  output logic                             out_first__RDY,
`ifdef FIFO_STRIPE_FLUSH_EN
  input  logic                             flush,
`endif
  output logic [$clog2(lanes*depth+1)-1:0] count
);

  localparam int LW = (lanes > 1) ? $clog2(lanes) : 1;
  localparam int PW = $clog2(depth) + 1;
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam int CW = $clog2(lanes*depth+1);
  localparam logic [PW-1:0] WRAP  = PW'(1) << (PW-1);
  localparam logic [AW-1:0] AMASK = AW'(depth-1);
  localparam logic [LW-1:0] LAST  = LW'(lanes-1);

  logic [LW-1:0]    wsel, rsel;
  logic [PW-1:0]    wptr [lanes];
  logic [PW-1:0]    rptr [lanes];
  logic [width-1:0] mem  [lanes][depth];
  logic [lanes-1:0] full, empty;
  logic [AW-1:0]    waddr, raddr;
  logic             enq_fire, deq_fire, clr;

`ifdef FIFO_STRIPE_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // Full: pointers differ only in the wrap bit; empty: pointers identical.
  always_comb begin
    full  = '0;
    empty = '0;
    for (int i = 0; i < lanes; i++) begin
      full[i]  = ((wptr[i] ^ rptr[i]) == WRAP);
      empty[i] = (wptr[i] == rptr[i]);
    end
  end

  assign in_enq__RDY    = !full[wsel] && !clr;
  assign out_deq__RDY   = !empty[rsel] && !clr;
  assign out_first__RDY = out_deq__RDY;

  // The wrap bit is masked off to address storage; depth==1 always maps to slot 0.
  assign waddr = AW'(wptr[wsel]) & AMASK;
  assign raddr = AW'(rptr[rsel]) & AMASK;

  assign out_first = out_deq__RDY ? mem[rsel][raddr] : '0;
  assign enq_fire  = in_enq__ENA && in_enq__RDY;
  assign deq_fire  = out_deq__ENA && out_deq__RDY;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wsel  <= '0;
      rsel  <= '0;
      count <= '0;
      for (int i = 0; i < lanes; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else if (clr) begin
      wsel  <= '0;
      rsel  <= '0;
      count <= '0;
      for (int i = 0; i < lanes; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      if (enq_fire) begin
        wptr[wsel] <= wptr[wsel] + PW'(1);
        wsel       <= (wsel == LAST) ? '0 : wsel + LW'(1);
      end
      if (deq_fire) begin
        rptr[rsel] <= rptr[rsel] + PW'(1);
        rsel       <= (rsel == LAST) ? '0 : rsel + LW'(1);
      end
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; contents are only visible through non-empty lanes.
  always_ff @(posedge CLK) begin
    if (enq_fire)
      mem[wsel][waddr] <= in_enq_v;
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_stripe.sv
`default_nettype none
// tb_fifo_stripe: randomized and directed self-checking bench for fifo_stripe against a queue model.
module tb_fifo_stripe;
  localparam int W  = 8;
  localparam int L  = 4;
  localparam int D  = 2;
  localparam int CW = $clog2(L*D+1);

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          in_enq__ENA = 1'b0;
  logic [W-1:0]  in_enq_v = '0;
  logic          in_enq__RDY;
  logic          out_deq__ENA = 1'b0;
  logic          out_deq__RDY;
  logic [W-1:0]  out_first;
  logic          out_first__RDY;
  logic [CW-1:0] count;
  logic          flush = 1'b0;

  fifo_stripe #(.width(W), .lanes(L), .depth(D)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .in_enq__ENA    (in_enq__ENA),
    .in_enq_v       (in_enq_v),
    .in_enq__RDY    (in_enq__RDY),
    .out_deq__ENA   (out_deq__ENA),
    .out_deq__RDY   (out_deq__RDY),
    .out_first      (out_first),
    .out_first__RDY (out_first__RDY),
`ifdef FIFO_STRIPE_FLUSH_EN
    .flush          (flush),
`endif
    .count          (count)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  // Reference: one ordered queue plus global enqueue/dequeue sequence numbers.
  // Item number s lives in lane s % L; a lane is full when it holds D queued items.
  logic [W-1:0] mq[$];
  int enq_n = 0;
  int deq_n = 0;

  function automatic int lane_occ(int lane);
    int n = 0;
    for (int s = deq_n; s < enq_n; s++)
      if ((s % L) == lane) n++;
    return n;
  endfunction

  function automatic bit m_enq_rdy();
    return !flush && (lane_occ(enq_n % L) < D);
  endfunction

  function automatic bit m_deq_rdy();
    return !flush && (mq.size() > 0);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge nRST) begin
    mq.delete();
    enq_n = 0;
    deq_n = 0;
  end

  always @(posedge CLK) begin
    if (nRST) begin
      bit ef, df;
      ef = in_enq__ENA && m_enq_rdy();
      df = out_deq__ENA && m_deq_rdy();
      if (flush) begin
        mq.delete();
        enq_n = 0;
        deq_n = 0;
      end else begin
        if (df) begin
          void'(mq.pop_front());
          deq_n++;
        end
        if (ef) begin
          mq.push_back(in_enq_v);
          enq_n++;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      logic [W-1:0] exp_first;
      exp_first = m_deq_rdy() ? mq[0] : '0;
      check("m_enq_rdy",   32'(in_enq__RDY),    32'(m_enq_rdy()));
      check("m_deq_rdy",   32'(out_deq__RDY),   32'(m_deq_rdy()));
      check("m_first_rdy", 32'(out_first__RDY), 32'(m_deq_rdy()));
      check("m_first",     32'(out_first),      32'(exp_first));
      check("m_count",     32'(count),          32'(mq.size()));
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic drv(bit e, logic [W-1:0] d, bit q);
    in_enq__ENA  = e;
    in_enq_v     = d;
    out_deq__ENA = q;
  endtask

  initial begin
    tick();
    tick();
    check("in_reset_count", 32'(count), 32'd0);
    check("in_reset_enq_rdy", 32'(in_enq__RDY), 32'd1);
    nRST = 1'b1;
    tick();
    check("reset_enq_rdy", 32'(in_enq__RDY), 32'd1);
    check("reset_deq_rdy", 32'(out_deq__RDY), 32'd0);
    check("reset_first", 32'(out_first), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    cmp_en = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      drv(1'b1, W'(i), 1'b0);
      tick();
    end
    check("fill_count", 32'(count), 32'd8);
    check("fill_enq_rdy", 32'(in_enq__RDY), 32'd0);

    drv(1'b1, 8'hFF, 1'b0);
    tick();
    check("full_ignored_count", 32'(count), 32'd8);
    check("full_head", 32'(out_first), 32'h01);

    drv(1'b0, '0, 1'b1);
    tick();
    check("after_deq_enq_rdy", 32'(in_enq__RDY), 32'd1);
    check("after_deq_count", 32'(count), 32'd7);
    drv(1'b1, 8'hFF, 1'b0);
    tick();
    for (int i = 2; i <= 9; i++) begin
      check("order_first", 32'(out_first), (i == 9) ? 32'hFF : 32'(i));
      drv(1'b0, '0, 1'b1);
      tick();
    end
    drv(1'b0, '0, 1'b0);
    check("drained_count", 32'(count), 32'd0);
    check("drained_deq_rdy", 32'(out_deq__RDY), 32'd0);

    drv(1'b1, 8'h10, 1'b0);
    tick();
    for (int k = 1; k <= 20; k++) begin
      check("stream_first", 32'(out_first), 32'(8'h10 + k - 1));
      check("stream_count", 32'(count), 32'd1);
      drv(1'b1, W'(8'h10 + k), 1'b1);
      tick();
    end
    check("stream_last", 32'(out_first), 32'h24);
    drv(1'b0, '0, 1'b1);
    tick();
    drv(1'b0, '0, 1'b0);

    for (int i = 0; i < 5; i++) begin
      drv(1'b1, W'($urandom), 1'b0);
      tick();
    end
    drv(1'b0, '0, 1'b0);
    check("pre_reset_count", 32'(count), 32'd5);
    #2 nRST = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_deq_rdy", 32'(out_deq__RDY), 32'd0);
    check("async_enq_rdy", 32'(in_enq__RDY), 32'd1);
    check("async_first", 32'(out_first), 32'd0);
    tick();
    nRST = 1'b1;
    tick();

`ifdef FIFO_STRIPE_FLUSH_EN
    for (int i = 0; i < 3; i++) begin
      drv(1'b1, W'(8'h30 + i), 1'b0);
      tick();
    end
    check("pre_flush_count", 32'(count), 32'd3);
    drv(1'b1, 8'h77, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    drv(1'b1, 8'hA5, 1'b0);
    tick();
    check("flush_next_first", 32'(out_first), 32'hA5);
    drv(1'b0, '0, 1'b1);
    tick();
    drv(1'b0, '0, 1'b0);
`endif

    for (int c = 0; c < 600; c++) begin
      drv($urandom_range(0, 99) < 55, W'($urandom), $urandom_range(0, 99) < 50);
      tick();
    end
    for (int c = 0; c < 200; c++) begin
      drv($urandom_range(0, 99) < 90, W'($urandom), $urandom_range(0, 99) < 20);
      tick();
    end
    for (int c = 0; c < 12; c++) begin
      drv(1'b0, '0, 1'b1);
      tick();
    end
    drv(1'b0, '0, 1'b0);
    check("final_count", 32'(count), 32'd0);
    tick();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
